// File: rtl/instr_sequencer.sv
// instr_sequencer: control-side front end of the 4-bit datapath.
// Captures a 16-bit switch word on a debounced button press, decodes it into
// register-file addresses, opcode and write enable, and steps the pst state
// sequence (IDLE, FETCH, DECODE, READ, EXEC, DONE) that the register file and
// ALU key on. S_EXEC is the single write cycle.
//
// Ports
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   btn          raw step button, asynchronous to clk
//   instr_in     {opcode[15:12], wr[11:8], rs1[7:4], rs2[3:0]}
//   overflow     ALU overflow, only looked at in S_EXEC
//   underflow    ALU underflow, only looked at in S_EXEC
//   pst          current state code
//   opcode       latched opcode to the ALU
//   Rd1, Rd2     read addresses (rs1, rs2)
//   Wr           write address
//   Reg_Write    write permission, S_EXEC with a non-NOP opcode only
//   busy         high whenever pst is not S_IDLE
//   err_flag     sticky overflow/underflow of the current instruction
//   instr_count  completed instructions, wraps 255 -> 0
module instr_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [3:0]  NOP_OPCODE      = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [15:0] instr_in,
    input  logic        overflow,
    input  logic        underflow,
    output logic [3:0]  pst,
    output logic [3:0]  opcode,
    output logic [3:0]  Rd1,
    output logic [3:0]  Rd2,
    output logic [3:0]  Wr,
    output logic        Reg_Write,
    output logic        busy,
    output logic        err_flag,
    output logic [7:0]  instr_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0000,
        S_FETCH  = 4'b0001,
        S_DECODE = 4'b0010,
        S_READ   = 4'b0011,
        S_EXEC   = 4'b1110,
        S_DONE   = 4'b1111
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic               r_sync1;
    logic               r_sync2;
    logic [CNT_W-1:0]   r_db_cnt;
    logic               r_go;

    logic [15:0]        r_instr;
    logic [3:0]         r_opcode;
    logic [3:0]         r_rd1;
    logic [3:0]         r_rd2;
    logic [3:0]         r_wr;
    logic               r_err;
    logic [7:0]         r_count;

    logic [15:0]        w_instr_next;
    logic [3:0]         w_opcode_next;
    logic [3:0]         w_rd1_next;
    logic [3:0]         w_rd2_next;
    logic [3:0]         w_wr_next;
    logic               w_err_next;
    logic [7:0]         w_count_next;

    // Button synchronizer and saturating debounce counter; go is high for the
    // one cycle in which the counter first holds DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_go     <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != CNT_W'(DEBOUNCE_CYCLES)) begin
                r_db_cnt <= r_db_cnt + CNT_W'(1);
            end
            r_go <= r_sync2 && (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        w_state_next  = S_IDLE;
        w_instr_next  = r_instr;
        w_opcode_next = r_opcode;
        w_rd1_next    = r_rd1;
        w_rd2_next    = r_rd2;
        w_wr_next     = r_wr;
        w_err_next    = r_err;
        w_count_next  = r_count;
        case (r_state)
            S_IDLE: begin
                if (r_go) begin
                    w_state_next = S_FETCH;
                    w_instr_next = instr_in;
                    w_err_next   = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                w_state_next  = S_DECODE;
                w_opcode_next = r_instr[15:12];
                w_wr_next     = r_instr[11:8];
                w_rd1_next    = r_instr[7:4];
                w_rd2_next    = r_instr[3:0];
            end
            S_DECODE: w_state_next = S_READ;
            S_READ:   w_state_next = S_EXEC;
            S_EXEC: begin
                w_state_next = S_DONE;
                w_count_next = r_count + 8'd1;
                if (overflow || underflow) begin
                    w_err_next = 1'b1;
                end
            end
            // Wait for release so a held button cannot start a second instruction
            S_DONE:   w_state_next = r_sync2 ? S_DONE : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Instruction, decoded fields and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr  <= '0;
            r_opcode <= '0;
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_wr     <= '0;
            r_err    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_instr  <= w_instr_next;
            r_opcode <= w_opcode_next;
            r_rd1    <= w_rd1_next;
            r_rd2    <= w_rd2_next;
            r_wr     <= w_wr_next;
            r_err    <= w_err_next;
            r_count  <= w_count_next;
        end
    end

    // Decoded from registered state only, so it falls with the async reset
    assign Reg_Write   = (r_state == S_EXEC) && (r_opcode != NOP_OPCODE);
    assign busy        = (r_state != S_IDLE);
    assign pst         = r_state;
    assign opcode      = r_opcode;
    assign Rd1         = r_rd1;
    assign Rd2         = r_rd2;
    assign Wr          = r_wr;
    assign err_flag    = r_err;
    assign instr_count = r_count;

endmodule
